// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared memory port.
// slave  = the arbiter itself; master = the core/memory environment around it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  // Memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  // Status towards the control unit
  logic              stall;
  logic              bus_error;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_ack,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_rdata, m_ack,
    output stall, bus_error
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_ack,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_rdata, m_ack,
    input  stall, bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and load/store.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that exceed TIMEOUT
// BUSY cycles (DONE with zero data and bus_error). Default build waits forever.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // TIMEOUT-1 is the terminal count, so zero is meaningless
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be nonzero");
  end

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_i, pick_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Fetch wins when it is alone or when data was granted last
  assign pick_i = bus.i_req & (~bus.d_req | (last_grant_q == GRANT_D));
  assign pick_d = bus.d_req & ~pick_i;

  // Next-state and datapath capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          addr_d       = bus.i_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          be_d         = '1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else if (pick_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          addr_d       = bus.d_addr;
          we_d         = bus.d_we;
          wdata_d      = bus.d_wdata;
          be_d         = bus.d_be;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ack) begin
          if (state_q == BUSY_I) begin
            i_rdata_d = bus.m_rdata;
            state_d   = DONE_I;
          end else begin
            d_rdata_d = bus.m_rdata;
            state_d   = DONE_D;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          if (state_q == BUSY_I) begin
            i_rdata_d = '0;
            state_d   = DONE_I;
          end else begin
            d_rdata_d = '0;
            state_d   = DONE_D;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Outputs: registers or direct state decodes, except the combinational stall
  assign bus.m_req   = (state_q == BUSY_I) | (state_q == BUSY_D);
  assign bus.m_we    = we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_be    = be_q;
  assign bus.i_ack   = (state_q == DONE_I);
  assign bus.d_ack   = (state_q == DONE_D);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.stall   = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.bus_error = err_q;
`else
  assign bus.bus_error = 1'b0;
`endif

endmodule
